// File: rtl/lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu : single-outstanding load/store unit with sub-word strobes, load      |
// |       extension and a bus-ack timeout. Option: LSU_MISALIGN_TRAP_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_wr,
  input  logic [2:0]       mem_op,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             fault,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [3:0]       bus_wstrb,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        wr_q, wr_d;

  logic        op_valid;
  logic [1:0]  eff_off;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  // Request decode: lane offset is forced to the natural alignment of the size.
  always_comb begin
    op_valid = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010) ||
               (mem_op == 3'b100) || (mem_op == 3'b101);
    eff_off  = 2'b00;
    st_strb  = 4'b1111;
    st_data  = wdata;
    case (mem_op[1:0])
      2'b00: begin
        eff_off = addr[1:0];
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        eff_off = {addr[1], 1'b0};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                 ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    ld_shift = bus_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fault_d     = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    wr_d        = wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op_valid) begin
            state_d = S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (misaligned) begin
            state_d = S_DONE;
            fault_d = 1'b1;
`endif
          end else begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = mem_wr ? st_strb : 4'b0000;
            bus_wdata_d = mem_wr ? st_data : bus_wdata_q;
            cnt_d       = 8'd0;
            op_d        = mem_op;
            off_d       = eff_off;
            wr_d        = mem_wr;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack || (cnt_q + 8'd1 == TIMEOUT_C)) begin
          state_d     = S_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_wstrb_d = 4'b0000;
          if (bus_ack) begin
            if (!wr_q) rdata_d = ld_ext;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      wr_q        <= wr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire
